filter_mavg: RTL

//  Boxcar moving-average pre-filter for one acquisition channel, placed directly upstream of

---
 rtl/filter_mavg_if.sv | 23 ++
 rtl/filter_mavg.sv | 109 ++++++++++
 2 files changed

// File: rtl/filter_mavg_if.sv
// Sample stream into and averaged stream out of the moving-average pre-filter.
interface filter_mavg_if #(
    parameter int unsigned DATA_WD = 32
) ();
    logic               din_valid;
    logic [DATA_WD-1:0] din;
    logic               dout_valid;
    logic [DATA_WD-1:0] dout;

    modport master (
        output din_valid,
        output din,
        input  dout_valid,
        input  dout
    );

    modport slave (
        input  din_valid,
        input  din,
        output dout_valid,
        output dout
    );
endinterface

// File: rtl/filter_mavg.sv
// Boxcar moving average over the last 2^k samples; two-stage pipeline, one sample per cycle.
module filter_mavg #(
    parameter int unsigned DATA_WD  = 32,
    parameter int unsigned MAX_LOG2 = 6
) (
    input  logic           sys_clk,
    input  logic           sys_rst_n,
    input  logic           cfg_rst,
    input  logic [2:0]     win_sel,
    filter_mavg_if.slave   bus,
    output logic           fill_done
);
    localparam int unsigned DEPTH   = 1 << MAX_LOG2;
    localparam int unsigned PTR_WD  = MAX_LOG2;
    localparam int unsigned CNT_WD  = MAX_LOG2 + 1;
    localparam int unsigned DIFF_WD = DATA_WD + 1;
    localparam int unsigned ACC_WD  = DATA_WD + MAX_LOG2;
    localparam int unsigned K_WD    = 3;

    logic [DATA_WD-1:0]        buf_mem [DEPTH];
    logic [PTR_WD-1:0]         wr_ptr;
    logic [CNT_WD-1:0]         fill_cnt;
    logic [K_WD-1:0]           k_lat;
    logic                      s1_valid;
    logic                      s1_full;
    logic signed [DIFF_WD-1:0] diff_q;
    logic signed [ACC_WD-1:0]  acc_q;
    logic                      dout_valid_q;
    logic [DATA_WD-1:0]        dout_q;

    logic [K_WD-1:0]           k_req_c;
    logic [CNT_WD-1:0]         win_c;
    logic [PTR_WD-1:0]         rd_ptr_c;
    logic                      fill_full_c;
    logic [CNT_WD-1:0]         fill_cnt_nxt_c;
    logic [DATA_WD-1:0]        oldest_c;
    logic                      accept_c;
    logic signed [DIFF_WD-1:0] diff_c;
    logic signed [ACC_WD-1:0]  sum_c;
    logic [DATA_WD-1:0]        mean_c;

    // Window bookkeeping and S1 difference; an entry is only read once the window is full,
    // so slots not yet written since the last clear contribute zero.
    always_comb begin
        k_req_c        = (win_sel > K_WD'(MAX_LOG2)) ? K_WD'(MAX_LOG2) : win_sel;
        win_c          = CNT_WD'(1) << k_lat;
        rd_ptr_c       = wr_ptr - PTR_WD'(win_c);
        fill_full_c    = (fill_cnt == win_c);
        fill_cnt_nxt_c = fill_full_c ? fill_cnt : fill_cnt + CNT_WD'(1);
        oldest_c       = fill_full_c ? buf_mem[rd_ptr_c] : '0;
        accept_c       = bus.din_valid & ~cfg_rst;
        diff_c         = DIFF_WD'($signed(bus.din)) - DIFF_WD'($signed(oldest_c));
        sum_c          = acc_q + ACC_WD'(diff_q);
        mean_c         = DATA_WD'(sum_c >>> k_lat);
    end

    // Delay line storage; validity is tracked by fill_cnt so it needs no clear.
    always_ff @(posedge sys_clk) begin
        if (accept_c) begin
            buf_mem[wr_ptr] <= bus.din;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr       <= '0;
            fill_cnt     <= '0;
            k_lat        <= '0;
            s1_valid     <= 1'b0;
            s1_full      <= 1'b0;
            diff_q       <= '0;
            acc_q        <= '0;
            dout_valid_q <= 1'b0;
            dout_q       <= '0;
            fill_done    <= 1'b0;
        end else if (cfg_rst) begin
            wr_ptr       <= '0;
            fill_cnt     <= '0;
            k_lat        <= k_req_c;
            s1_valid     <= 1'b0;
            s1_full      <= 1'b0;
            diff_q       <= '0;
            acc_q        <= '0;
            dout_valid_q <= 1'b0;
            dout_q       <= '0;
            fill_done    <= 1'b0;
        end else begin
            s1_valid     <= accept_c;
            dout_valid_q <= s1_valid & s1_full;
            if (accept_c) begin
                diff_q   <= diff_c;
                s1_full  <= (fill_cnt_nxt_c == win_c);
                wr_ptr   <= wr_ptr + PTR_WD'(1);
                fill_cnt <= fill_cnt_nxt_c;
            end
            // dout only moves with a valid result so it holds through warm-up and gaps.
            if (s1_valid) begin
                acc_q <= sum_c;
                if (s1_full) begin
                    dout_q    <= mean_c;
                    fill_done <= 1'b1;
                end
            end
        end
    end

    assign bus.dout_valid = dout_valid_q;
    assign bus.dout       = dout_q;
endmodule
